// File: rtl/vending_pkg.sv
// Shared definitions for the vending transaction controller: coin encoding,
// coin-to-credit conversion and controller states.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  // Credit value of a coin in 5-units; invalid and absent coins are worth nothing.
  function automatic logic [1:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  return 2'd1;
      COIN_10: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_watchdog.sv
// Handshake watchdog: counts cycles spent waiting for a done pulse and flags
// expiry on the TIMEOUT-th waiting cycle.
module vend_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CW'(TIMEOUT - 1))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry must not depend on clear_i: clear is derived from the next state,
  // which itself depends on expiry.
  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/vending_ctrl.sv
// Vending transaction controller: credit accumulation, per-item stock,
// motor/hopper handshakes, refunds and a sticky watchdog fault.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 7,
  parameter int STOCK_INIT = 2,
  parameter int STOCK_W    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  output logic       coin_accept,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       refund_req,
  input  logic       restock,
  output logic       motor_go,
  output logic [1:0] motor_item,
  input  logic       motor_done,
  output logic       hopper_go,
  input  logic       hopper_done,
  output logic [2:0] credit,
  output logic [3:0] sold_out,
  output logic       busy,
  output logic       fault
);

  state_e             state_q, state_d;
  logic [2:0]         credit_q, credit_d;
  logic               motor_go_q, motor_go_d;
  logic [1:0]         motor_item_q, motor_item_d;
  logic               hopper_go_q, hopper_go_d;
  logic               fault_q, fault_d;
  logic [STOCK_W-1:0] stock_q [4];
  logic [STOCK_W-1:0] stock_d [4];

  logic [3:0] coin_sum;
  logic [2:0] credit_in;
  logic       can_vend, do_refund;
  logic       wd_clear, wd_enable, wd_expired;

  // Sum is one bit wider than credit so an over-limit coin cannot wrap.
  assign coin_sum    = {1'b0, credit_q} + {2'b00, coin_value(coin)};
  assign coin_accept = (state_q == ST_IDLE) && (coin != COIN_BAD)
                       && (coin_sum <= 4'(MAX_CREDIT));
  assign credit_in   = coin_accept ? coin_sum[2:0] : credit_q;
  assign can_vend    = sel_valid && (credit_q >= 3'(PRICE)) && (stock_q[sel_item] != '0);
  assign do_refund   = refund_req && (credit_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (can_vend)       state_d = ST_VEND;
        else if (do_refund) state_d = ST_CHANGE;
      end
      ST_VEND: begin
        if (motor_done)      state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
        else if (wd_expired) state_d = ST_FAULT;
      end
      ST_CHANGE: begin
        if (hopper_done) begin
          if (credit_q == 3'd1) state_d = ST_IDLE;
        end else if (wd_expired) begin
          state_d = ST_FAULT;
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  always_comb begin
    credit_d     = credit_q;
    motor_go_d   = motor_go_q;
    motor_item_d = motor_item_q;
    hopper_go_d  = hopper_go_q;
    fault_d      = fault_q;
    for (int i = 0; i < 4; i++) stock_d[i] = stock_q[i];
    case (state_q)
      ST_IDLE: begin
        if (restock) begin
          for (int i = 0; i < 4; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
        end
        if (can_vend) begin
          credit_d     = credit_in - 3'(PRICE);
          motor_go_d   = 1'b1;
          motor_item_d = sel_item;
        end else if (do_refund) begin
          credit_d    = credit_in;
          hopper_go_d = 1'b1;
        end else begin
          credit_d = credit_in;
        end
      end
      ST_VEND: begin
        if (motor_done) begin
          motor_go_d = 1'b0;
          if (stock_q[motor_item_q] != '0) begin
            stock_d[motor_item_q] = stock_q[motor_item_q] - STOCK_W'(1);
          end
          if (credit_q != '0) hopper_go_d = 1'b1;
        end else if (wd_expired) begin
          motor_go_d = 1'b0;
          fault_d    = 1'b1;
        end
      end
      ST_CHANGE: begin
        if (hopper_done) begin
          credit_d = credit_q - 3'd1;
          if (credit_q == 3'd1) hopper_go_d = 1'b0;
        end else if (wd_expired) begin
          hopper_go_d = 1'b0;
          fault_d     = 1'b1;
        end
      end
      default: begin
        motor_go_d  = 1'b0;
        hopper_go_d = 1'b0;
        fault_d     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q     <= '0;
      motor_go_q   <= 1'b0;
      motor_item_q <= '0;
      hopper_go_q  <= 1'b0;
      fault_q      <= 1'b0;
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      credit_q     <= credit_d;
      motor_go_q   <= motor_go_d;
      motor_item_q <= motor_item_d;
      hopper_go_q  <= hopper_go_d;
      fault_q      <= fault_d;
      stock_q      <= stock_d;
    end
  end

  // One counter serves both handshakes since only one is ever outstanding.
  assign wd_enable = (state_q == ST_VEND) || (state_q == ST_CHANGE);
  assign wd_clear  = (state_d != state_q)
                     || ((state_q == ST_VEND) && motor_done)
                     || ((state_q == ST_CHANGE) && hopper_done);

  vend_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign credit     = credit_q;
  assign motor_go   = motor_go_q;
  assign motor_item = motor_item_q;
  assign hopper_go  = hopper_go_q;
  assign busy       = (state_q != ST_IDLE);
  assign fault      = fault_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Self-checking bench for vending_ctrl: vector table plus hand-written
// watchdog/reset sequences, outputs checked through a scoreboard queue.
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       coin_accept;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       refund_req;
  logic       restock;
  logic       motor_go;
  logic [1:0] motor_item;
  logic       motor_done;
  logic       hopper_go;
  logic       hopper_done;
  logic [2:0] credit;
  logic [3:0] sold_out;
  logic       busy;
  logic       fault;

  int total = 0;
  int bad   = 0;

  vending_ctrl #(
    .PRICE(4), .MAX_CREDIT(7), .STOCK_INIT(2), .STOCK_W(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .coin(coin), .coin_accept(coin_accept),
    .sel_valid(sel_valid), .sel_item(sel_item), .refund_req(refund_req),
    .restock(restock), .motor_go(motor_go), .motor_item(motor_item),
    .motor_done(motor_done), .hopper_go(hopper_go), .hopper_done(hopper_done),
    .credit(credit), .sold_out(sold_out), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  // ca: 0/1 expected coin_accept before the edge, 2 = not checked.
  typedef struct {
    int coin, sel, item, refund, restock, md, hd;
    int ca;
    int credit, mgo, mitem, hgo, busy, sold, fault;
  } vec_t;

  vec_t        tbl[$];
  logic [12:0] sb_q[$];

  function automatic vec_t mk(int c, int s, int it, int rf, int rs, int md, int hd,
                              int ca, int cr, int mg, int mi, int hg, int bz,
                              int so, int f);
    vec_t v;
    v.coin = c; v.sel = s; v.item = it; v.refund = rf; v.restock = rs;
    v.md = md; v.hd = hd; v.ca = ca; v.credit = cr; v.mgo = mg; v.mitem = mi;
    v.hgo = hg; v.busy = bz; v.sold = so; v.fault = f;
    return v;
  endfunction

  function automatic logic [12:0] outs_now();
    return {credit, motor_go, motor_item, hopper_go, busy, sold_out, fault};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    logic [12:0] exp;
    @(negedge clk);
    coin        = v.coin[1:0];
    sel_valid   = v.sel[0];
    sel_item    = v.item[1:0];
    refund_req  = v.refund[0];
    restock     = v.restock[0];
    motor_done  = v.md[0];
    hopper_done = v.hd[0];
    #1;
    if (v.ca != 2) check({nm, ".coin_accept"}, 32'(coin_accept), 32'(v.ca));
    exp = {v.credit[2:0], v.mgo[0], v.mitem[1:0], v.hgo[0], v.busy[0],
           v.sold[3:0], v.fault[0]};
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({nm, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check({nm, ".outs{cr,mg,mi,hg,bz,so,f}"}, 32'(outs_now()), 32'(exp));
    end
  endtask

  initial begin
    rst = 1'b0; coin = 2'b00; sel_valid = 1'b0; sel_item = 2'd0;
    refund_req = 1'b0; restock = 1'b0; motor_done = 1'b0; hopper_done = 1'b0;

    //      coin sel it rf rs md hd  ca  cr mg mi hg bz so f
    // 1: two 10s, vend item 1, motor_done after three cycles
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 2,0,0,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 4,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0, 2, 0,1,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0, 0,1,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0, 0,1,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 2, 0,0,1,0,0,0,0));
    // 2: 5+10+10, vend item 0, one coin of change
    tbl.push_back(mk(1,0,0,0,0,0,0, 1, 1,0,1,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 3,0,1,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 5,0,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0, 2, 1,1,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0, 1,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0, 0,0,0,0,0,0,0));
    // 3: credit ceiling and invalid coin, then vend item 3 with 3 change
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 2,0,0,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 4,0,0,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 6,0,0,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 0, 6,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, 1, 7,0,0,0,0,0,0));
    tbl.push_back(mk(3,0,0,0,0,0,0, 0, 7,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,3,0,0,0,0, 2, 3,1,3,0,1,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 0, 3,1,3,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0, 3,0,3,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0, 2,0,3,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0, 2,0,3,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0, 1,0,3,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0, 0,0,3,0,0,0,0));
    // 4: sell out item 2, ignored select, refund of 4, restock
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 2,0,3,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 4,0,3,0,0,0,0));
    tbl.push_back(mk(0,1,2,0,0,0,0, 2, 0,1,2,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0, 0,0,2,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 2,0,2,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 4,0,2,0,0,0,0));
    tbl.push_back(mk(0,1,2,0,0,0,0, 2, 0,1,2,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0, 0,0,2,0,0,4,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 2,0,2,0,0,4,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 4,0,2,0,0,4,0));
    tbl.push_back(mk(0,1,2,0,0,0,0, 2, 4,0,2,0,0,4,0));
    tbl.push_back(mk(0,0,0,1,0,0,0, 2, 4,0,2,1,1,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0, 3,0,2,1,1,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0, 2,0,2,1,1,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0, 1,0,2,1,1,4,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0, 0,0,2,0,0,4,0));
    tbl.push_back(mk(0,0,0,0,1,0,0, 2, 0,0,2,0,0,0,0));
    // 5: select plus same-cycle coin; refund and select together
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 2,0,2,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 4,0,2,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 1, 1,1,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0, 1,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1, 0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 2,0,0,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 4,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,0, 2, 0,1,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,1,0, 0, 0,0,1,0,0,0,0));
    // stray done pulses in IDLE are ignored; build credit 5 for the watchdog run
    tbl.push_back(mk(1,0,0,0,0,1,1, 1, 1,0,1,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 3,0,1,0,0,0,0));
    tbl.push_back(mk(2,0,0,0,0,0,0, 1, 5,0,1,0,0,0,0));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.outs", 32'(outs_now()), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // 6: withhold motor_done; fault on the 16th waiting cycle, not before
    apply(mk(0,1,0,0,0,0,0, 2, 1,1,0,0,1,0,0), "wd.enter");
    for (int k = 1; k <= 15; k++)
      apply(mk(0,0,0,0,0,0,0, 0, 1,1,0,0,1,0,0), $sformatf("wd.wait%0d", k));
    apply(mk(0,0,0,0,0,0,0, 0, 1,0,0,0,1,0,1), "wd.expire");
    apply(mk(2,1,1,1,1,1,1, 0, 1,0,0,0,1,0,1), "fault.frozen");
    apply(mk(0,0,0,0,0,0,0, 0, 1,0,0,0,1,0,1), "fault.sticky");

    // asynchronous reset in FAULT, away from any clock edge
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("fault.reset_outs", 32'(outs_now()), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // stock of item 0 is back to 2: first vend leaves it available, second sells out
    apply(mk(2,0,0,0,0,0,0, 1, 2,0,0,0,0,0,0), "rs.c1");
    apply(mk(2,0,0,0,0,0,0, 1, 4,0,0,0,0,0,0), "rs.c2");
    apply(mk(0,1,0,0,0,0,0, 2, 0,1,0,0,1,0,0), "rs.sel1");
    apply(mk(0,0,0,0,0,1,0, 0, 0,0,0,0,0,0,0), "rs.done1");
    apply(mk(2,0,0,0,0,0,0, 1, 2,0,0,0,0,0,0), "rs.c3");
    apply(mk(2,0,0,0,0,0,0, 1, 4,0,0,0,0,0,0), "rs.c4");
    apply(mk(0,1,0,0,0,0,0, 2, 0,1,0,0,1,0,0), "rs.sel2");
    apply(mk(0,0,0,0,0,1,0, 0, 0,0,0,0,0,1,0), "rs.done2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
